// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if -- handshake and memory-port bundle for fifo_wr_arbiter.
//
// Optional macro: FIFO_WR_ARBITER_ALMOST_FULL_EN adds walmost_full.
//
// Signals:
//   req_valid  NREQ           per-requester write request
//   req_data   NREQ*DATASIZE  requester i data in [i*DATASIZE +: DATASIZE]
//   req_ready  NREQ           one-hot grant
//   wq2_rptr   ADDRSIZE+1     Gray read pointer synchronized into wclk
//   wclken     1              memory write enable
//   waddr      ADDRSIZE       memory write address
//   wdata      DATASIZE       memory write data
//   wptr       ADDRSIZE+1     registered Gray write pointer
//   wfull      1              registered full flag
//   grant_id   IDW            index of granted requester (0 when idle)
//   walmost_full 1            registered almost-full flag (macro only)
// Modports: slave = arbiter side, master = requesters / reader side.
interface fifo_wr_arbiter_if #(
   parameter int DATASIZE = 8,
   parameter int ADDRSIZE = 4,
   parameter int NREQ     = 4
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]          req_valid;
   logic [NREQ*DATASIZE-1:0] req_data;
   logic [NREQ-1:0]          req_ready;
   logic [ADDRSIZE:0]        wq2_rptr;
   logic                     wclken;
   logic [ADDRSIZE-1:0]      waddr;
   logic [DATASIZE-1:0]      wdata;
   logic [ADDRSIZE:0]        wptr;
   logic                     wfull;
   logic [IDW-1:0]           grant_id;
`ifdef FIFO_WR_ARBITER_ALMOST_FULL_EN
   logic                     walmost_full;
`endif

   modport slave (
      input  req_valid, req_data, wq2_rptr,
      output req_ready, wclken, waddr, wdata, wptr, wfull, grant_id
`ifdef FIFO_WR_ARBITER_ALMOST_FULL_EN
      , walmost_full
`endif
   );

   modport master (
      output req_valid, req_data, wq2_rptr,
      input  req_ready, wclken, waddr, wdata, wptr, wfull, grant_id
`ifdef FIFO_WR_ARBITER_ALMOST_FULL_EN
      , walmost_full
`endif
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter -- round-robin arbiter feeding the write side of an
// asynchronous FIFO. One word per cycle is granted to the first valid
// requester at or after the round-robin pointer, written to memory at the
// binary write pointer, and the Gray write pointer / full flag are registered.
//
// Optional macro: FIFO_WR_ARBITER_ALMOST_FULL_EN adds parameter AF_THRESH and
// the registered walmost_full output (free slots <= AF_THRESH).
//
// Ports:
//   wclk    in   write-domain clock (rising edge)
//   wrst_n  in   asynchronous active-low reset
//   bus     slave modport of fifo_wr_arbiter_if (requests, grants, memory
//           write port, Gray pointers, status flags)
module fifo_wr_arbiter #(
   parameter int DATASIZE  = 8,
   parameter int ADDRSIZE  = 4,
   parameter int NREQ      = 4
`ifdef FIFO_WR_ARBITER_ALMOST_FULL_EN
   , parameter int AF_THRESH = 2
`endif
) (
   input logic               wclk,
   input logic               wrst_n,
   fifo_wr_arbiter_if.slave  bus
);
   localparam int          IDW    = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned NREQ_U = NREQ;

   logic [ADDRSIZE:0]   wbin_q, wbin_d;
   logic [ADDRSIZE:0]   wptr_q, wgray_d;
   logic                wfull_q, wfull_d;
   logic [IDW-1:0]      rr_q, rr_d;

   logic [NREQ-1:0]     ready;
   logic [IDW-1:0]      gid;
   logic [DATASIZE-1:0] gdata;
   logic                found;
   int unsigned         idx;

   // Round-robin search from rr_q; reset and full both suppress any grant, so
   // a grant always implies a transfer.
   always_comb begin
      ready = '0;
      gid   = '0;
      gdata = '0;
      found = 1'b0;
      idx   = 0;
      if (wrst_n && !wfull_q) begin
         for (int unsigned k = 0; k < NREQ_U; k++) begin
            idx = (32'(rr_q) + k) % NREQ_U;
            if (!found && bus.req_valid[idx]) begin
               found      = 1'b1;
               ready[idx] = 1'b1;
               gid        = IDW'(idx);
               gdata      = bus.req_data[idx*DATASIZE +: DATASIZE];
            end
         end
      end
   end

   always_comb begin
      wbin_d  = wbin_q + {{ADDRSIZE{1'b0}}, found};
      wgray_d = wbin_d ^ (wbin_d >> 1);
      // Full when the next Gray write pointer equals the read pointer with
      // its two MSBs inverted (write side one full lap ahead).
      wfull_d = (wgray_d == {~bus.wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                             bus.wq2_rptr[ADDRSIZE-2:0]});
      rr_d    = rr_q;
      if (found) begin
         rr_d = (32'(gid) == NREQ_U - 1) ? '0 : gid + 1'b1;
      end
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wbin_q  <= '0;
         wptr_q  <= '0;
         wfull_q <= 1'b0;
         rr_q    <= '0;
      end else begin
         wbin_q  <= wbin_d;
         wptr_q  <= wgray_d;
         wfull_q <= wfull_d;
         rr_q    <= rr_d;
      end
   end

`ifdef FIFO_WR_ARBITER_ALMOST_FULL_EN
   localparam int unsigned DEPTH = 1 << ADDRSIZE;

   logic [ADDRSIZE:0]   rbin;
   logic [ADDRSIZE:0]   used;
   logic [ADDRSIZE+1:0] free_w;
   logic                waf_q, waf_d;

   always_comb begin
      rbin[ADDRSIZE] = bus.wq2_rptr[ADDRSIZE];
      for (int unsigned i = 0; i < ADDRSIZE; i++) begin
         rbin[ADDRSIZE-1-i] = rbin[ADDRSIZE-i] ^ bus.wq2_rptr[ADDRSIZE-1-i];
      end
      used   = wbin_d - rbin;
      free_w = (ADDRSIZE+2)'(DEPTH) - {1'b0, used};
      waf_d  = (free_w <= (ADDRSIZE+2)'(AF_THRESH));
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         waf_q <= 1'b0;
      end else begin
         waf_q <= waf_d;
      end
   end

   assign bus.walmost_full = waf_q;
`endif

   assign bus.req_ready = ready;
   assign bus.wclken    = found;
   assign bus.grant_id  = gid;
   assign bus.wdata     = gdata;
   assign bus.waddr     = wbin_q[ADDRSIZE-1:0];
   assign bus.wptr      = wptr_q;
   assign bus.wfull     = wfull_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: behavioural model based on write/read counts,
// compared against the DUT on every falling edge, plus literal expectations.
module tb_fifo_wr_arbiter;
   localparam int DS    = 8;
   localparam int AS    = 4;
   localparam int NR    = 4;
   localparam int DEPTH = 16;

   logic wclk   = 1'b0;
   logic wrst_n = 1'b1;

   always #5 wclk = ~wclk;

   fifo_wr_arbiter_if #(.DATASIZE(DS), .ADDRSIZE(AS), .NREQ(NR)) bus ();

   fifo_wr_arbiter #(.DATASIZE(DS), .ADDRSIZE(AS), .NREQ(NR)) dut (
      .wclk   (wclk),
      .wrst_n (wrst_n),
      .bus    (bus.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: total words written, round-robin start, registered flags.
   int          m_w    = 0;
   int          m_rr   = 0;
   bit          m_full = 1'b0;
   bit          m_af   = 1'b0;
   int unsigned rd_cnt = 0;
   int          log_id[$];
   int          log_addr[$];

   function automatic logic [AS:0] gray(input int unsigned v);
      logic [AS:0] b;
      b = (AS+1)'(v % 32);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic drive_rd(input int unsigned r);
      rd_cnt       = r;
      bus.wq2_rptr = gray(r);
   endtask

   task automatic set_data(input logic [DS-1:0] base);
      for (int i = 0; i < NR; i++) bus.req_data[i*DS +: DS] = base + DS'(i);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge wclk);
      #1;
   endtask

   always @(negedge wclk) begin
      int            g;
      int            idx;
      logic [NR-1:0] er;
      logic [DS-1:0] ed;
      if (!wrst_n) begin
         m_w = 0; m_rr = 0; m_full = 1'b0; m_af = 1'b0;
         chk("rst_ready",  bus.req_ready, 0);
         chk("rst_wclken", bus.wclken,    0);
         chk("rst_wptr",   bus.wptr,      0);
         chk("rst_wfull",  bus.wfull,     0);
      end else begin
         g = -1;
         if (!m_full) begin
            for (int k = 0; k < NR; k++) begin
               idx = (m_rr + k) % NR;
               if (g < 0 && bus.req_valid[idx]) g = idx;
            end
         end
         er = '0;
         ed = '0;
         if (g >= 0) begin
            er[g] = 1'b1;
            ed    = bus.req_data[g*DS +: DS];
         end
         chk("req_ready", bus.req_ready, er);
         chk("wclken",    bus.wclken,    (g >= 0) ? 1 : 0);
         chk("grant_id",  bus.grant_id,  (g >= 0) ? g : 0);
         chk("wdata",     bus.wdata,     ed);
         chk("waddr",     bus.waddr,     m_w % DEPTH);
         chk("wptr",      bus.wptr,      gray(m_w));
         chk("wfull",     bus.wfull,     m_full);
`ifdef FIFO_WR_ARBITER_ALMOST_FULL_EN
         chk("walmost_full", bus.walmost_full, m_af);
`endif
         if (bus.wclken === 1'b1) begin
            log_id.push_back(int'(bus.grant_id));
            log_addr.push_back(int'(bus.waddr));
         end
         if (g >= 0) begin
            m_w++;
            m_rr = (g + 1) % NR;
         end
         m_full = ((m_w - int'(rd_cnt)) & 31) == DEPTH;
         m_af   = (DEPTH - ((m_w - int'(rd_cnt)) & 31)) <= 2;
      end
   end

   initial begin
      logic [AS:0] wptr_before;
      bus.req_valid = '0;
      bus.req_data  = '0;
      drive_rd(0);
      #1 wrst_n = 1'b0;
      step(3);
      chk("reset_wptr_lit",  bus.wptr,      0);
      chk("reset_wfull_lit", bus.wfull,     0);
      chk("reset_ready_lit", bus.req_ready, 0);
      wrst_n = 1'b1;

      // All four requesting, empty FIFO, reader idle.
      set_data(8'hA0);
      log_id.delete(); log_addr.delete();
      bus.req_valid = 4'hF;
      step(20);
      chk("s1_nwrites", log_id.size(), 16);
      for (int i = 0; i < 16 && i < log_id.size(); i++) begin
         chk("s1_order", log_id[i],   i % 4);
         chk("s1_addr",  log_addr[i], i);
      end
      chk("s1_wfull_lit",  bus.wfull,  1);
      chk("s1_no_wclken",  bus.wclken, 0);

      // Reader frees one slot.
      log_id.delete(); log_addr.delete();
      drive_rd(1);
      step(1);
      chk("s2_wfull_clear", bus.wfull, 0);
      step(3);
      chk("s2_nwrites", log_id.size(), 1);
      if (log_addr.size() > 0) chk("s2_addr", log_addr[0], 0);
      chk("s2_wfull_again", bus.wfull, 1);

      // Single requester, reader keeping pace, address and MSB wrap.
      bus.req_valid = '0;
      drive_rd(17);
      step(1);
      wptr_before = bus.wptr;
      log_id.delete(); log_addr.delete();
      set_data(8'hC0);
      bus.req_valid = 4'b0100;
      for (int i = 0; i < 20; i++) begin
         step(1);
         drive_rd(m_w);
      end
      bus.req_valid = '0;
      chk("s3_nwrites", log_id.size(), 20);
      for (int i = 0; i < log_id.size(); i++) chk("s3_id", log_id[i], 2);
      if (log_addr.size() >= 16) begin
         chk("s3_addr_first", log_addr[0],  1);
         chk("s3_addr_15",    log_addr[14], 15);
         chk("s3_addr_wrap",  log_addr[15], 0);
      end
      chk("s3_msb_before", wptr_before[AS], 1);
      chk("s3_msb_after",  bus.wptr[AS],    0);
      chk("s3_wfull",      bus.wfull,       0);

      // Reset mid-burst after five writes.
      set_data(8'h50);
      log_id.delete(); log_addr.delete();
      bus.req_valid = 4'hF;
      step(5);
      chk("s4_nwrites_pre", log_id.size(), 5);
      wrst_n = 1'b0;
      drive_rd(0);
      #1;
      chk("s4_rst_wptr",   bus.wptr,      0);
      chk("s4_rst_wfull",  bus.wfull,     0);
      chk("s4_rst_ready",  bus.req_ready, 0);
      chk("s4_rst_wclken", bus.wclken,    0);
      step(2);
      log_id.delete(); log_addr.delete();
      wrst_n = 1'b1;
      step(1);
      chk("s4_nwrites_post", log_id.size(), 1);
      if (log_id.size() > 0) begin
         chk("s4_id",   log_id[0],   0);
         chk("s4_addr", log_addr[0], 0);
      end

`ifdef FIFO_WR_ARBITER_ALMOST_FULL_EN
      // Almost-full threshold with no reads.
      wrst_n = 1'b0;
      step(1);
      wrst_n = 1'b1;
      step(13);
      chk("s5_af_13", bus.walmost_full, 0);
      step(1);
      chk("s5_af_14",    bus.walmost_full, 1);
      chk("s5_wfull_14", bus.wfull,        0);
      step(2);
      chk("s5_wfull_16", bus.wfull, 1);
`endif

      bus.req_valid = '0;
      step(2);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter DATASIZE, default 8, memory word width in bits.
REQ-002 SHALL have parameter ADDRSIZE, default 4, memory address width; depth = 2**ADDRSIZE.
REQ-003 SHALL have parameter NREQ, default 4, number of write requesters (2..8); IDW = clog2(NREQ).
REQ-004 SHALL have port wclk  input  1  write-domain clock; sole clock, all state on rising edge.
REQ-005 SHALL have port wrst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req_valid  input  NREQ  per-requester write request.
REQ-007 SHALL have port req_data  input  NREQ*DATASIZE  requester i data in bits [i*DATASIZE +: DATASIZE].
REQ-008 SHALL have port req_ready  output  NREQ  one-hot grant; a word transfers when req_valid[i] & req_ready[i].
REQ-009 SHALL have port wq2_rptr  input  ADDRSIZE+1  Gray read pointer, already synchronized into wclk.
REQ-010 SHALL have port wclken  output  1  memory write enable.
REQ-011 SHALL have port waddr  output  ADDRSIZE  memory write address.
REQ-012 SHALL have port wdata  output  DATASIZE  memory write data.
REQ-013 SHALL have port wptr  output  ADDRSIZE+1  registered Gray write pointer for the read domain.
REQ-014 SHALL have port wfull  output  1  registered full flag.
REQ-015 SHALL have port grant_id  output  IDW  index of the granted requester; 0 when no grant.

Function
REQ-016 SHALL grant, combinationally, the first asserted req_valid at or after rr_ptr in round-robin order (rr_ptr, rr_ptr+1, ... mod NREQ).
REQ-017 SHALL assert no req_ready bit while wfull=1 or no req_valid is asserted.
REQ-018 SHALL drive wclken = |(req_valid & req_ready) in the same cycle, with waddr = wbin[ADDRSIZE-1:0] and wdata = granted requester's data (0 when idle).
REQ-019 SHALL increment binary pointer wbin (ADDRSIZE+1 bits, wraps 2**(ADDRSIZE+1)-1 -> 0) by 1 on each edge with wclken=1; wptr = Gray(wbin) registered.
REQ-020 SHALL register wfull = (Gray(wbin_next) == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}) every edge, so full is visible the cycle after the 16th write (default).
REQ-021 SHALL deassert wfull the first edge after wq2_rptr advances away from the full relation.
REQ-022 SHALL load rr_ptr = (grant_id+1) mod NREQ on each edge with a transfer, otherwise hold it.
REQ-023 SHALL accept at most one word per cycle; data of ungranted requesters is not consumed, and requesters SHALL hold valid/data until granted.
REQ-024 SHALL never write when wfull=1, even with req_valid asserted (overflow impossible).
REQ-025 SHALL sustain one write per cycle back-to-back from the same or different requesters.

Reset
REQ-026 SHALL on wrst_n=0, immediately and asynchronously, clear wbin, wptr, wfull, rr_ptr (requester 0 highest priority) to 0.
REQ-027 SHALL force req_ready=0 and wclken=0 while wrst_n=0; an in-flight request is dropped, with no partial write.
REQ-028 SHALL resume granting on the first rising edge after wrst_n deasserts.

Configuration
REQ-029 SHALL, with macro FIFO_WR_ARBITER_ALMOST_FULL_EN defined, add parameter AF_THRESH (default 2) and a registered output walmost_full, asserted when free slots (depth - (wbin_next - Gray2Bin(wq2_rptr))) <= AF_THRESH, reset 0.
REQ-030 SHALL, without the macro, have neither the walmost_full port nor its logic and no Gray-to-binary converter.

Verification
REQ-031 SHALL cover: reset, then all four req_valid=1 continuously, empty FIFO, wq2_rptr=0 -> grant order 0,1,2,3,0,...; waddr 0..15; wfull=1 after 16th write; no wclken afterward.
REQ-032 SHALL cover: full FIFO, wq2_rptr advanced to Gray(1) -> wfull=0 next edge; exactly one write to waddr 0, then wfull=1 again.
REQ-033 SHALL cover: only req_valid[2] held for 20 cycles, reader keeping pace -> 20 consecutive grants to 2, waddr wraps 15->0, wptr MSB toggles.
REQ-034 SHALL cover: wrst_n pulsed low mid-burst after 5 writes -> wptr=0, wfull=0, req_ready=0 immediately; next grant to requester 0 at waddr 0.
REQ-035 SHALL cover: macro defined, AF_THRESH=2, no reads -> walmost_full=1 after 14th write, wfull=1 after 16th; macro undefined -> port absent, scenario REQ-031 unchanged.
